// File: rtl/chaos_pkg.sv
// Shared constants, FSM encoding and seeding helper for the chaotic random source.
package chaos_pkg;

    localparam int NCH   = 5;
    localparam int STEPS = 2 * NCH;

    typedef enum logic [1:0] {IDLE, WARM, GEN, HOLD} state_t;

    localparam logic [0:4][31:0] SALT = {
        32'h0000_0000, 32'h9E37_79B9, 32'h7F4A_7C15, 32'hD1B5_4A32, 32'h2545_F491
    };

    localparam logic [0:4][31:0] RESEED = {
        32'h6A09_E667, 32'hBB67_AE85, 32'h3C6E_F372, 32'hA54F_F53A, 32'h510E_527F
    };

    // A zero state is a fixed point of the map, so it is replaced by a fixed nonzero value.
    function automatic logic [31:0] seed_chan(input logic [2:0] c, input logic [31:0] seed);
        logic [31:0] v;
        v = seed ^ SALT[c];
        return (v == '0) ? RESEED[c] : v;
    endfunction

endpackage

// File: rtl/logistic_step.sv
// One logistic-map iteration over two cycles on a single shared multiplier:
// phase A registers t = x*(1-x), phase B produces y = MU*t with degeneracy replacement.
module logistic_step
    import chaos_pkg::*;
#(
    parameter logic [31:0] MU = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        phase_b,
    input  logic [31:0] x,
    input  logic [31:0] reseed,
    output logic [31:0] y
);

    logic [32:0] op_a;
    logic [32:0] op_b;
    logic [65:0] prod;
    logic [31:0] t_q;
    logic [31:0] y_raw;
    logic        unused_prod;

    always_comb begin
        if (phase_b) begin
            op_a = {1'b0, MU};
            op_b = {1'b0, t_q};
        end else begin
            op_a = {1'b0, x};
            op_b = 33'h1_0000_0000 - {1'b0, x};
        end
    end

    assign prod  = {33'd0, op_a} * {33'd0, op_b};
    assign y_raw = prod[61:30];
    // A collapsed orbit (zero or fixed point) would stall the channel forever.
    assign y     = (y_raw == '0 || y_raw == x) ? reseed : y_raw;

    assign unused_prod = ^{prod[65:64], prod[29:0]};

    always_ff @(posedge clk) begin
        if (rst)
            t_q <= '0;
        else if (en && !phase_b)
            t_q <= prod[63:32];
    end

endmodule

// File: rtl/chaos_rand_src.sv
// Five logistic-map channels sharing one step unit, presented as a valid/ready tuple source.
module chaos_rand_src
    import chaos_pkg::*;
#(
    parameter int          CHAOS_OVLD_W = 32,
    parameter logic [31:0] MU           = 32'hFC00_0000,
    parameter int unsigned WARMUP       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_load,
    input  logic [31:0]             seed,
    output logic [CHAOS_OVLD_W-1:0] rand_x1,
    output logic [CHAOS_OVLD_W-1:0] rand_x2,
    output logic [CHAOS_OVLD_W-1:0] rand_x3,
    output logic [CHAOS_OVLD_W-1:0] rand_z1,
    output logic [CHAOS_OVLD_W-1:0] rand_z2,
    output logic                    rand_vld,
    input  logic                    rand_rdy,
    output logic                    busy
);

    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
    localparam state_t      START     = (WARMUP == 0) ? GEN : WARM;

    state_t      state, state_n;
    logic [3:0]  step_cnt;
    logic [15:0] round_cnt;
    logic [31:0] chan [NCH];
    logic [2:0]  ch;
    logic        phase_b;
    logic        running;
    logic        last_step;
    logic        last_round;
    logic [31:0] x_cur;
    logic [31:0] y;

    assign ch         = step_cnt[3:1];
    assign phase_b    = step_cnt[0];
    assign running    = (state == WARM) || (state == GEN);
    assign last_step  = (step_cnt == 4'(STEPS - 1));
    assign last_round = (round_cnt == WARM_LAST);
    assign x_cur      = chan[ch];
    assign busy       = running;

    logistic_step #(.MU(MU)) u_step (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .phase_b (phase_b),
        .x       (x_cur),
        .reseed  (RESEED[ch]),
        .y       (y)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (seed_load) state_n = START;
            WARM:    if (last_step && last_round) state_n = GEN;
            GEN:     if (last_step) state_n = HOLD;
            HOLD:    if (rand_rdy) state_n = GEN;
            default: state_n = IDLE;
        endcase
        // A new seed overrides everything, including a coincident handshake.
        if (seed_load)
            state_n = START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            round_cnt <= '0;
            rand_vld  <= 1'b0;
            rand_x1   <= '0;
            rand_x2   <= '0;
            rand_x3   <= '0;
            rand_z1   <= '0;
            rand_z2   <= '0;
            for (int c = 0; c < NCH; c++)
                chan[c] <= '0;
        end else if (seed_load) begin
            step_cnt  <= '0;
            round_cnt <= '0;
            rand_vld  <= 1'b0;
            for (int c = 0; c < NCH; c++)
                chan[c] <= seed_chan(3'(c), seed);
        end else begin
            if (running) begin
                step_cnt <= last_step ? 4'd0 : step_cnt + 4'd1;
                if (phase_b)
                    chan[ch] <= y;
                if (state == WARM && last_step)
                    round_cnt <= round_cnt + 16'd1;
                // Channel 4's new value is still on y at this edge.
                if (state == GEN && last_step) begin
                    rand_x1  <= chan[0];
                    rand_x2  <= chan[1];
                    rand_x3  <= chan[2];
                    rand_z1  <= chan[3];
                    rand_z2  <= y;
                    rand_vld <= 1'b1;
                end
            end
            if (state == HOLD && rand_rdy)
                rand_vld <= 1'b0;
        end
    end

endmodule
